// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs field-level instruction requests into RV32I
// R-type / S-type words and writes them sequentially into instruction memory.
// One word is accepted, then written on the following cycle (1 word / 2 cycles).
module instr_encoder_loader #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [3:0]        in_alu_op,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        word_q, word_d;
    logic               last_q;
    logic               err_q, done_q, in_ready_q, imem_we_q;

    // Encode the incoming request; only captured on a legal handshake.
    always_comb begin
        word_d = {1'b0, in_alu_op[3], 5'b0, in_rs2, in_rs1, in_alu_op[2:0], in_rd, 7'b0110011};
        if (in_type == 2'b01)
            word_d = {in_imm[11:5], in_rs2, in_rs1, in_alu_op[2:0], in_imm[4:0], 7'b0100011};
    end

    // Session FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= BASE;
            count_q    <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            imem_we_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        ptr_q      <= BASE;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (in_type[1]) begin
                            // Illegal type: flag it, write nothing.
                            err_q <= 1'b1;
                            if (in_last) begin
                                state_q    <= S_DONE;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end else begin
                            state_q    <= S_WRITE;
                            word_q     <= word_d;
                            last_q     <= in_last;
                            in_ready_q <= 1'b0;
                            imem_we_q  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we_q <= 1'b0;
                    count_q   <= count_q + CNT_W'(1);
                    // Pointer saturates at the top word so it can never wrap.
                    if (ptr_q != LAST_PTR)
                        ptr_q <= ptr_q + ADDR_W'(1);
                    if (last_q || ptr_q == LAST_PTR) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        ptr_q      <= BASE;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        done_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else if (in_valid) begin
                        // Requests after termination are dropped but flagged.
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = ptr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart to the control unit's instruction decode.
- Takes field-level instruction requests (type, registers, ALU op, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit RV32I R-type or S-type word, using the same {func7[5], func3} ALU-op convention the decoder consumes.
- Writes the words sequentially into instruction memory. Used by the bench and boot path to load programs before the core runs.

Parameters:
- DEPTH, 64, instruction memory size in 32-bit words.
- ADDR_W, $clog2(DEPTH), word-address width.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: begin a load session. Honoured only in IDLE or DONE.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
- in_type  input  2  00 = R-type, 01 = S-type, 1x = illegal.
- in_rd  input  5  destination register (R-type only).
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_alu_op  input  4  {func7[5], func3}.
- in_imm  input  12  S-type immediate.
- in_last  input  1  final request of the session.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  words written this session.
- done  output  1  session complete (level).
- err  output  1  sticky: illegal type, or overflow attempt.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; in_ready, imem_we, done, err = 0; imem_addr=BASE_ADDR; imem_wdata=0; count=0.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start -> LOAD. Write pointer=BASE_ADDR, count=0, err=0.
- LOAD:
  - in_ready=1.
  - On handshake with legal type: register encoded word and pointer, go to WRITE.
  - Illegal type: set err, write nothing, count unchanged. If in_last, go to DONE; else stay in LOAD.
- WRITE:
  - Exactly one cycle; in_ready=0, imem_we=1, imem_addr=pointer, imem_wdata=word.
  - Next edge: pointer+1, count+1.
  - Next state: DONE if the registered last flag is set or the pointer was DEPTH-1; else LOAD.
- DONE:
  - done=1, in_ready=0.
  - start -> LOAD with pointer, count, err cleared and done dropped.
  - Any in_valid seen while in DONE (before restart) sets err and is ignored.
- Latency and throughput:
  - Handshake at edge N -> imem_we high during cycle N+1 -> in_ready high again in cycle N+2 (if not terminated).
  - Throughput: 1 word per 2 cycles.
- R-type encoding: {1'b0, alu_op[3], 5'b0, rs2, rs1, alu_op[2:0], rd, 7'b0110011}.
- S-type encoding: {imm[11:5], rs2, rs1, alu_op[2:0], imm[4:0], 7'b0100011}. alu_op[3] and rd are ignored.
- imem_wdata holds its last value when imem_we=0. imem_we is never asserted outside WRITE.
- Pointer never wraps. Reaching DEPTH words forces DONE even without in_last.
- start outside IDLE/DONE is ignored.
- reset_n low mid-WRITE: strobe drops immediately (async); the partial session is abandoned.

Test Plan:
- Reset, start, R-type rd=3 rs1=1 rs2=2 alu_op=0000 in_last=1 -> one write at addr 0, wdata=0x002081B3; count=1; done=1 in the following cycle.
- R-type rd=5 rs1=6 rs2=7 alu_op=1000 (sub) -> wdata=0x407302B3.
- S-type rs1=1 rs2=2 imm=8 alu_op=0010 (sw) -> wdata=0x0020A423.
- Back-to-back in_valid held high for 3 requests -> writes at addr 0,1,2 on alternating cycles; in_ready low during each WRITE cycle; count=3.
- DEPTH=4, 5 requests with no in_last -> 4 writes, done=1 after addr 3; 5th in_valid sets err=1 and produces no imem_we.
- in_type=10 mid-session -> err=1, no write, count unchanged. Next legal request is written at the next sequential address. Pulling reset_n low during WRITE clears imem_we, done, count and err at once.
